la_axis_egress_arb: RTL and testbench
=====================================

// Module: la_axis_egress_arb
// PURPOSE
//  Packet-atomic AXI-Stream arbiter sharing one AXIS master (toward the upstream axis switch) between two sources:
//  - port 0: the logic-analyzer trace stream.
//  - port 1: the user-project stream.
//  Default policy is round-robin. While la_hpri_req is high, port 0 has strict priority; a starvation counter bounds how long port 1 can be locked out.
// PARAMETERS
//  pDATA_WIDTH   32  tdata width; tstrb/tkeep are pDATA_WIDTH/8
//  STARVE_PKTS   4   consecutive port-0 packets granted while port 1 waits before port 1 is forced one packet (1..255)
// PORTS
//  axis_clk       in   1   single clock for all logic
//  axis_rst       in   1   synchronous, active-high reset
//  s0_tdata/tstrb/tkeep/tlast/tvalid/tuser  in  32/4/4/1/1/2   LA trace stream
//  s0_tready      out  1   ready to LA source
//  la_hpri_req    in   1   LA high-priority request (FIFO above threshold)
//  s1_tdata/tstrb/tkeep/tlast/tvalid/tuser  in  32/4/4/1/1/2   user-project stream
//  s1_tready      out  1   ready to user source
//  m_tdata/tstrb/tkeep/tlast/tvalid/tuser   out 32/4/4/1/1/2   muxed output stream
//  m_tready       in   1   downstream ready
//  m_tsrc         out  1   source id of the current beat (0=LA, 1=UP); valid while m_tvalid
//  arb_busy       out  1   high while a packet is in flight (state != IDLE)
// BEHAVIOUR
//  - Reset state: IDLE, last_gnt=1 (so port 0 wins first RR tie), starve_cnt=0.
//  - Output values during reset: m_tvalid=0, s0_tready=0, s1_tready=0, m_tsrc=0, arb_busy=0.
//  - States:
//    - IDLE: no grant.
//    - GNT0, GNT1: the selected port owns the master until its tlast beat is accepted.
//  - Datapath is combinational in GNTx:
//    - m_* = sx_*; sx_tready = m_tready; the other port's tready = 0.
//    - In IDLE: m_tvalid=0 and both treadys=0.
//    - One beat transfers when m_tvalid & m_tready.
//  - Arbitration decision: evaluated in IDLE, and on the cycle the tlast beat is accepted.
//    - Priority order:
//      (a) force1 = s1_tvalid & (starve_cnt == STARVE_PKTS) -> port 1
//      (b) la_hpri_req & s0_tvalid -> port 0
//      (c) both valid -> port != last_gnt
//      (d) the single valid port
//      (e) none -> IDLE
//    - Decision is registered: the grant takes effect the next cycle.
//    - Latency: 1 idle-free cycle from IDLE; back-to-back packets lose no cycle (tlast-accept cycle re-arbitrates directly into GNTx).
//  - Packet boundaries: a grant is never revoked mid-packet. la_hpri_req rising during a port-1 packet takes effect only after that packet's tlast beat.
//  - starve_cnt (8 bit, saturating at STARVE_PKTS), updated on each packet grant:
//    - port-0 grant while s1_tvalid=1: +1
//    - any port-1 grant: clear to 0
//    - port-0 grant with s1_tvalid=0: clear to 0
//  - last_gnt is updated on every grant.
//  - tvalid dropping mid-packet: the grant is held and m_tvalid follows the source; no timeout.
//  - Single-beat packet (tvalid & tlast on the first beat): legal. The state returns through the re-arbitration path.
//  - AXIS rules: the arbiter never creates or drops beats. m_tdata is stable while m_tvalid & !m_tready, provided the source obeys AXIS.
//  - Reset mid-packet: the state goes to IDLE next edge and the packet is truncated; the source is responsible for its own reset.
// STRUCTURE
//  - Shared package la_pkg:
//    - arb state enum {ARB_IDLE, ARB_GNT0, ARB_GNT1}
//    - SRC_LA=1'b0, SRC_UP=1'b1
//    - AXIS_TUSER_W=2
//  - Sub-module la_rr_pick (2-way round-robin/priority picker; inputs req[1:0], hpri, force1, last_gnt; outputs gnt_vld, gnt_id; purely combinational). The FSM, counter and mux stay in the top.
// TESTING
//  - Only s0 sends 3 packets of 8 beats, m_tready=1 -> 24 beats on m_*, m_tsrc=0, no bubble between packets, m_tlast on beats 8/16/24.
//  - Both valid continuously, la_hpri_req=0, 4-beat packets -> grants alternate 0,1,0,1; first grant is port 0.
//  - la_hpri_req=1, both valid, STARVE_PKTS=4 -> pattern 0,0,0,0,1,0,0,0,0,1.
//  - During a 6-beat port-1 packet, raise la_hpri_req at beat 2 -> port 1 completes all 6 beats before port 0 is granted.
//  - m_tready toggled 1010 during a port-0 packet -> m_tdata/m_tlast hold when stalled; the s1 stream sees s1_tready=0 throughout.
//  - Assert axis_rst mid-packet -> the next cycle shows m_tvalid=0, both treadys=0, arb_busy=0; the first post-reset grant goes to port 0.

Source files
------------

// File: rtl/la_axis_egress_arb_pkg.sv
// Shared types for the LA egress arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package la_pkg;

  localparam int AXIS_TUSER_W = 2;

  // Source identifiers, also used as the m_tsrc encoding.
  localparam logic SRC_LA = 1'b0;
  localparam logic SRC_UP = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/la_axis_egress_arb_if.sv
// AXI-Stream bundle: tdata/tstrb/tkeep/tlast/tvalid/tuser forward, tready back.
// Latency: n/a (wires only).
// Backpressure: tready from the slave side gates each tvalid beat.
// Ports: master drives the forward signals and samples tready; slave the reverse.
interface la_axis_if #(
  parameter int DATA_W = 32
);
  import la_pkg::*;

  logic [DATA_W-1:0]       tdata;
  logic [DATA_W/8-1:0]     tstrb;
  logic [DATA_W/8-1:0]     tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic [AXIS_TUSER_W-1:0] tuser;
  logic                    tready;

  modport master (
    output tdata, tstrb, tkeep, tlast, tvalid, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tlast, tvalid, tuser,
    output tready
  );

endinterface

// File: rtl/la_axis_egress_arb_rr_pick.sv
// Two-way picker: forced port 1, then LA high priority, then round-robin.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req[1:0] per-port requests, hpri LA priority, force1 starvation override,
//        last_gnt previous winner; gnt_vld/gnt_id the chosen port.
module la_rr_pick
  import la_pkg::*;
(
  input  logic [1:0] req,
  input  logic       hpri,
  input  logic       force1,
  input  logic       last_gnt,
  output logic       gnt_vld,
  output logic       gnt_id
);

  always_comb begin
    gnt_vld = 1'b1;
    gnt_id  = SRC_LA;
    if (force1) begin
      gnt_id = SRC_UP;
    end else if (hpri && req[0]) begin
      gnt_id = SRC_LA;
    end else if (&req) begin
      // Tie: the port that did not win last time.
      gnt_id = ~last_gnt;
    end else if (req[0]) begin
      gnt_id = SRC_LA;
    end else if (req[1]) begin
      gnt_id = SRC_UP;
    end else begin
      gnt_vld = 1'b0;
    end
  end

endmodule

// File: rtl/la_axis_egress_arb.sv
// Packet-atomic arbiter muxing LA trace (s0) and user stream (s1) onto one AXIS master.
// Latency: one cycle from request in IDLE to grant; back-to-back packets lose no cycle.
// Backpressure: m.tready passes straight to the granted source; the other sees tready=0.
// Ports: axis_clk/axis_rst (sync, active high), s0/s1 slave streams, la_hpri_req,
//        m master stream, m_tsrc source of the current beat, arb_busy packet in flight.
module la_axis_egress_arb
  import la_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int STARVE_PKTS = 4
) (
  input  logic      axis_clk,
  input  logic      axis_rst,
  la_axis_if.slave  s0,
  input  logic      la_hpri_req,
  la_axis_if.slave  s1,
  la_axis_if.master m,
  output logic      m_tsrc,
  output logic      arb_busy
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_PKTS);

  arb_state_t state_q, state_d;
  logic       last_gnt_q;
  logic [7:0] starve_q;

  logic own;
  logic sel1;
  logic tlast_acc;
  logic arb_en;
  logic force1;
  logic gnt_vld;
  logic gnt_id;

  logic [pDATA_WIDTH-1:0]   mux_tdata;
  logic [pDATA_WIDTH/8-1:0] mux_tstrb;
  logic [pDATA_WIDTH/8-1:0] mux_tkeep;

  // Outputs are forced quiet while reset is held, even before the state clears.
  assign own  = (state_q != ARB_IDLE) && !axis_rst;
  assign sel1 = (state_q == ARB_GNT1);

  assign mux_tdata = sel1 ? s1.tdata : s0.tdata;
  assign mux_tstrb = sel1 ? s1.tstrb : s0.tstrb;
  assign mux_tkeep = sel1 ? s1.tkeep : s0.tkeep;

  assign m.tdata  = mux_tdata;
  assign m.tstrb  = mux_tstrb;
  assign m.tkeep  = mux_tkeep;
  assign m.tuser  = sel1 ? s1.tuser : s0.tuser;
  assign m.tlast  = sel1 ? s1.tlast : s0.tlast;
  assign m.tvalid = own && (sel1 ? s1.tvalid : s0.tvalid);

  assign s0.tready = own && !sel1 && m.tready;
  assign s1.tready = own && sel1 && m.tready;

  assign m_tsrc   = (own && sel1) ? SRC_UP : SRC_LA;
  assign arb_busy = own;

  // Re-arbitrate when idle, or on the tlast handshake so the next packet
  // starts on the following cycle without a bubble.
  assign tlast_acc = m.tvalid && m.tready && m.tlast;
  assign arb_en    = (state_q == ARB_IDLE) || tlast_acc;
  assign force1    = s1.tvalid && (starve_q == STARVE_MAX);

  la_rr_pick u_pick (
    .req      ({s1.tvalid, s0.tvalid}),
    .hpri     (la_hpri_req),
    .force1   (force1),
    .last_gnt (last_gnt_q),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    if (arb_en) begin
      if (!gnt_vld)
        state_d = ARB_IDLE;
      else if (gnt_id == SRC_UP)
        state_d = ARB_GNT1;
      else
        state_d = ARB_GNT0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= SRC_UP;
      starve_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      if (arb_en && gnt_vld) begin
        last_gnt_q <= gnt_id;
        // Count only LA packets that overtake a waiting user packet.
        if (gnt_id == SRC_UP || !s1.tvalid)
          starve_q <= 8'd0;
        else if (starve_q != STARVE_MAX)
          starve_q <= starve_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_la_axis_egress_arb.sv
module tb_la_axis_egress_arb;
  import la_pkg::*;

  localparam int STARVE = 4;

  logic axis_clk = 1'b0;
  logic axis_rst = 1'b1;
  logic la_hpri_req = 1'b0;
  logic m_tsrc;
  logic arb_busy;

  la_axis_if #(.DATA_W(32)) s0_if ();
  la_axis_if #(.DATA_W(32)) s1_if ();
  la_axis_if #(.DATA_W(32)) m_if ();

  la_axis_egress_arb #(.pDATA_WIDTH(32), .STARVE_PKTS(STARVE)) dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .s0          (s0_if),
    .la_hpri_req (la_hpri_req),
    .s1          (s1_if),
    .m           (m_if),
    .m_tsrc      (m_tsrc),
    .arb_busy    (arb_busy)
  );

  always #5 axis_clk = ~axis_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- source drivers ----------------
  bit drv_en = 1'b0;
  bit rdy_rand = 1'b0;
  bit hpri_rand = 1'b0;
  bit sv[2];
  bit fire[2];
  int beat[2], cur_len[2], pkt_id[2], pk_left[2], len_cfg[2], gap_pct[2];

  // npk<0: endless; len==0: random 1..6 beats per packet
  task automatic src_cfg(input int p, input int npk, input int len, input int gap);
    pk_left[p] = npk;
    len_cfg[p] = len;
    gap_pct[p] = gap;
    beat[p]    = 0;
    pkt_id[p]  = 0;
    sv[p]      = 1'b0;
    cur_len[p] = (len == 0) ? int'($urandom_range(6, 1)) : len;
  endtask

  always @(posedge axis_clk) begin
    #1;
    for (int p = 0; p < 2; p++) begin
      if (fire[p]) begin
        if (beat[p] == cur_len[p] - 1) begin
          beat[p] = 0;
          pkt_id[p]++;
          if (pk_left[p] > 0) pk_left[p]--;
          cur_len[p] = (len_cfg[p] == 0) ? int'($urandom_range(6, 1)) : len_cfg[p];
        end else begin
          beat[p]++;
        end
      end
      if (!drv_en) sv[p] = 1'b0;
      else if (!(sv[p] && !fire[p])) sv[p] = (pk_left[p] != 0) && ($urandom_range(99) >= gap_pct[p]);
    end
    s0_if.tvalid = sv[0];
    s0_if.tdata  = {8'd0, 8'(pkt_id[0]), 16'(beat[0])};
    s0_if.tlast  = (beat[0] == cur_len[0] - 1);
    s0_if.tuser  = 2'(beat[0]);
    s0_if.tkeep  = 4'hF;
    s0_if.tstrb  = 4'(pkt_id[0] + 1);
    s1_if.tvalid = sv[1];
    s1_if.tdata  = {8'd1, 8'(pkt_id[1]), 16'(beat[1])};
    s1_if.tlast  = (beat[1] == cur_len[1] - 1);
    s1_if.tuser  = 2'(beat[1] + 2);
    s1_if.tkeep  = 4'(pkt_id[1] + 3);
    s1_if.tstrb  = 4'h5;
    if (rdy_rand) m_if.tready = ($urandom_range(99) < 70);
    if (hpri_rand && $urandom_range(15) == 0) la_hpri_req = ~la_hpri_req;
  end

  // ---------------- reference model + monitor ----------------
  int mdl_own = -1;   // -1 none, else port that owns the master
  int mdl_last = 1;
  int mdl_starve = 0;
  int cyc = 0;
  bit acc_src[$];
  bit acc_last[$];
  int acc_cyc[$];

  function automatic int pick(bit v0, bit v1, bit hp);
    if (v1 && mdl_starve == STARVE) return 1;
    if (hp && v0) return 0;
    if (v0 && v1) return 1 - mdl_last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(negedge axis_clk) begin
    bit ev, el, v0, v1;
    int g;
    logic [4:0]  act_c, exp_c;
    logic [42:0] act_d, exp_d;
    cyc++;
    v0 = (s0_if.tvalid === 1'b1);
    v1 = (s1_if.tvalid === 1'b1);
    fire[0] = v0 && (s0_if.tready === 1'b1);
    fire[1] = v1 && (s1_if.tready === 1'b1);
    act_c = {m_if.tvalid, s0_if.tready, s1_if.tready, arb_busy, m_tsrc & m_if.tvalid};
    ev = 1'b0;
    el = 1'b0;
    exp_c = 5'b0;
    exp_d = '0;
    if (!axis_rst && mdl_own >= 0) begin
      ev = (mdl_own == 0) ? v0 : v1;
      el = (mdl_own == 0) ? s0_if.tlast : s1_if.tlast;
      exp_c = {ev, (mdl_own == 0) && m_if.tready, (mdl_own == 1) && m_if.tready, 1'b1, ev && (mdl_own == 1)};
      exp_d = (mdl_own == 0) ? {s0_if.tlast, s0_if.tstrb, s0_if.tkeep, s0_if.tuser, s0_if.tdata}
                             : {s1_if.tlast, s1_if.tstrb, s1_if.tkeep, s1_if.tuser, s1_if.tdata};
    end
    chk("ctrl", 64'(act_c), 64'(exp_c));
    if (ev) begin
      act_d = {m_if.tlast, m_if.tstrb, m_if.tkeep, m_if.tuser, m_if.tdata};
      chk("beat", 64'(act_d), 64'(exp_d));
    end
    if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      acc_src.push_back(m_tsrc);
      acc_last.push_back(m_if.tlast);
      acc_cyc.push_back(cyc);
    end
    if (axis_rst) begin
      mdl_own = -1;
      mdl_last = 1;
      mdl_starve = 0;
    end else if (mdl_own < 0 || (ev && m_if.tready && el)) begin
      g = pick(v0, v1, la_hpri_req);
      if (g >= 0) begin
        mdl_last = g;
        if (g == 0 && v1) mdl_starve = (mdl_starve < STARVE) ? mdl_starve + 1 : STARVE;
        else mdl_starve = 0;
      end
      mdl_own = g;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge axis_clk);
    #2;
  endtask

  task automatic nedge();
    @(negedge axis_clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    drv_en = 1'b0;
    rdy_rand = 1'b0;
    hpri_rand = 1'b0;
    la_hpri_req = 1'b0;
    m_if.tready = 1'b1;
    axis_rst = 1'b1;
    repeat (3) tick();
    axis_rst = 1'b0;
    acc_src.delete();
    acc_last.delete();
    acc_cyc.delete();
  endtask

  task automatic wait_acc(input int n, input string name);
    int c = 0;
    while (acc_src.size() < n && c < 600) begin
      nedge();
      c++;
    end
    chk(name, 64'(acc_src.size() >= n), 64'd1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          n0, l0, n1, l1;
    bit          hp;
    int          ngnt;
    logic [15:0] gseq;   // bit i = port of grant i
    logic [63:0] lmask;  // bit j = tlast on accepted beat j
  } vec_t;

  vec_t tbl[3];

  initial begin
    logic [15:0] gs;
    logic [63:0] lm;
    int np, total, k, c, cnt1;

    tbl[0] = '{n0: 3, l0: 8, n1: 0, l1: 4, hp: 1'b0, ngnt: 3,  gseq: 16'h0000, lmask: 64'h0000_0000_0080_8080};
    tbl[1] = '{n0: 3, l0: 4, n1: 3, l1: 4, hp: 1'b0, ngnt: 6,  gseq: 16'h002A, lmask: 64'h0000_0000_0088_8888};
    tbl[2] = '{n0: 8, l0: 4, n1: 2, l1: 4, hp: 1'b1, ngnt: 10, gseq: 16'h0210, lmask: 64'h0000_0088_8888_8888};

    m_if.tready = 1'b1;
    nedge();
    chk("rst_out", 64'({m_if.tvalid, s0_if.tready, s1_if.tready, arb_busy, m_tsrc}), 64'd0);

    for (int i = 0; i < 3; i++) begin
      do_reset();
      la_hpri_req = tbl[i].hp;
      src_cfg(0, tbl[i].n0, tbl[i].l0, 0);
      src_cfg(1, tbl[i].n1, tbl[i].l1, 0);
      drv_en = 1'b1;
      total = tbl[i].n0 * tbl[i].l0 + tbl[i].n1 * tbl[i].l1;
      wait_acc(total, "tbl_done");
      gs = '0;
      lm = '0;
      np = 0;
      for (int j = 0; j < acc_src.size() && j < 64; j++) begin
        if (j == 0 || acc_last[j-1]) begin
          if (np < 16) gs[np] = acc_src[j];
          np++;
        end
        lm[j] = acc_last[j];
      end
      chk("tbl_grants", 64'({np[15:0], gs}), 64'({tbl[i].ngnt[15:0], tbl[i].gseq}));
      chk("tbl_tlast", lm, tbl[i].lmask);
      if (acc_cyc.size() > 0)
        chk("tbl_nobubble", 64'(acc_cyc[acc_cyc.size()-1] - acc_cyc[0] + 1), 64'(total));
    end

    // hpri raised during a port-1 packet: that packet completes first
    do_reset();
    src_cfg(0, 0, 3, 0);
    src_cfg(1, 1, 6, 0);
    drv_en = 1'b1;
    wait_acc(2, "a_start");
    tick();
    src_cfg(0, 2, 3, 0);
    la_hpri_req = 1'b1;
    wait_acc(12, "a_done");
    if (acc_src.size() >= 7) begin
      cnt1 = 0;
      for (int j = 0; j < 6; j++) cnt1 += int'(acc_src[j]);
      chk("a_p1_whole", 64'(cnt1), 64'd6);
      chk("a_p1_last", 64'(acc_last[5]), 64'd1);
      chk("a_then_p0", 64'(acc_src[6]), 64'd0);
    end

    // m_tready toggling during a port-0 packet
    do_reset();
    la_hpri_req = 1'b1;
    src_cfg(0, 1, 6, 0);
    src_cfg(1, 2, 4, 0);
    drv_en = 1'b1;
    c = 0;
    do begin
      nedge();
      c++;
    end while (!arb_busy && c < 20);
    chk("b_busy", 64'(arb_busy), 64'd1);
    k = 0;
    c = 0;
    while (k < 6 && c < 30) begin
      chk("b_s1_rdy", 64'(s1_if.tready), 64'd0);
      chk("b_s0_rdy", 64'(s0_if.tready), 64'(m_if.tready));
      chk("b_beat", 64'({m_if.tvalid, m_if.tlast, m_if.tdata}), 64'({1'b1, k == 5, 32'(k)}));
      if (m_if.tready) k++;
      c++;
      if (k < 6) begin
        tick();
        m_if.tready = ~m_if.tready;
        nedge();
      end
    end
    chk("b_all_beats", 64'(k), 64'd6);
    tick();
    m_if.tready = 1'b1;

    // reset in the middle of a port-0 packet
    do_reset();
    src_cfg(0, -1, 8, 0);
    src_cfg(1, -1, 8, 0);
    drv_en = 1'b1;
    wait_acc(3, "c_start");
    tick();
    axis_rst = 1'b1;
    drv_en = 1'b0;
    nedge();
    chk("c_in_rst", 64'({m_if.tvalid, s0_if.tready, s1_if.tready, arb_busy, m_tsrc}), 64'd0);
    tick();
    axis_rst = 1'b0;
    acc_src.delete();
    acc_last.delete();
    acc_cyc.delete();
    src_cfg(0, -1, 8, 0);
    src_cfg(1, -1, 8, 0);
    drv_en = 1'b1;
    nedge();
    chk("c_post_rst", 64'({m_if.tvalid, s0_if.tready, s1_if.tready, arb_busy}), 64'd0);
    wait_acc(1, "c_regrant");
    if (acc_src.size() > 0) chk("c_first_p0", 64'(acc_src[0]), 64'd0);

    // random traffic against the reference model
    do_reset();
    src_cfg(0, -1, 0, 30);
    src_cfg(1, -1, 0, 30);
    rdy_rand = 1'b1;
    hpri_rand = 1'b1;
    drv_en = 1'b1;
    repeat (3000) tick();
    chk("rnd_activity", 64'(acc_src.size() > 200), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
